// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a sync_fifo and the logic on its single clock.
// The master side writes and pops; the slave side is the FIFO itself.
interface sync_fifo_if #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH_WIDTH = 11
);
  logic                        write;
  logic [DATA_WIDTH-1:0]       data_write;
  logic                        read;
  logic [DATA_WIDTH-1:0]       data_read;
  logic                        full;
  logic                        empty;
  logic                        almost_full;
  logic                        almost_empty;
  logic [FIFO_DEPTH_WIDTH:0]   data_count;
  logic                        overflow;
  logic                        underflow;

  modport master (
    output write, data_write, read,
    input  data_read, full, empty, almost_full, almost_empty,
           data_count, overflow, underflow
  );

  modport slave (
    input  write, data_write, read,
    output data_read, full, empty, almost_full, almost_empty,
           data_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through reads, a full-range
// occupancy count, programmable almost thresholds, synchronous flush and sticky errors.
module sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH_WIDTH = 11,
  parameter int FWFT             = 0,
  parameter int AF_THRESH        = (1 << FIFO_DEPTH_WIDTH) - 4,
  parameter int AE_THRESH        = 4
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clr,
  sync_fifo_if.slave  bus
);
  localparam int CW    = FIFO_DEPTH_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_WIDTH;

  typedef logic [CW-1:0]               cnt_t;
  typedef logic [FIFO_DEPTH_WIDTH-1:0] ptr_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
  localparam cnt_t AF_CNT    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_CNT    = cnt_t'(AE_THRESH);
  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam ptr_t PTR_ONE   = ptr_t'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic we, re;

  // Acceptance looks only at the registered flags, so a read at full never
  // frees room for a same-cycle write, and vice versa at empty.
  assign we = bus.write && !full_q  && !clr;
  assign re = bus.read  && !empty_q && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (we) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (re) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (we && !re)      count_d = count_q + CNT_ONE;
      else if (re && !we) count_d = count_q - CNT_ONE;
      if (bus.write && full_q) ovf_d = 1'b1;
      if (bus.read && empty_q) udf_d = 1'b1;
    end
    full_d   = (count_d == DEPTH_CNT);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_CNT);
    aempty_d = (count_d <= AE_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= bus.data_write;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_read = mem[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata_q <= '0;
        else if (re) rdata_q <= mem[rd_ptr_q];
      end
      assign bus.data_read = rdata_q;
    end
  endgenerate

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.data_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and checks
// both against a queue model every cycle, plus hand-computed spot values.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] dataWrite = '0;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW)) busStd ();
  sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW)) busFw ();

  assign busStd.write      = write;
  assign busStd.data_write = dataWrite;
  assign busStd.read       = read;
  assign busFw.write       = write;
  assign busFw.data_write  = dataWrite;
  assign busFw.read        = read;

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW), .FWFT(0),
              .AF_THRESH(AF), .AE_THRESH(AE))
    uStd (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(busStd));

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW), .FWFT(1),
              .AF_THRESH(AF), .AE_THRESH(AE))
    uFw (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(busFw));

  always #5 clk = ~clk;

  // Reference: a queue of stored words, the last popped word and the sticky errors.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] mLast;
  logic          mOv, mUn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mLast <= '0;
      mOv   <= 1'b0;
      mUn   <= 1'b0;
    end else if (clr) begin
      mq.delete();
      mOv <= 1'b0;
      mUn <= 1'b0;
    end else begin
      if (write && mq.size() == DEPTH) mOv <= 1'b1;
      if (read && mq.size() == 0)      mUn <= 1'b1;
      case ({write && mq.size() != DEPTH, read && mq.size() != 0})
        2'b10: mq.push_back(dataWrite);
        2'b01: mLast <= mq.pop_front();
        2'b11: begin
          mLast <= mq.pop_front();
          mq.push_back(dataWrite);
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkFlags(input string tag, input logic [AW:0] cnt, input logic e, input logic f,
                            input logic ae, input logic af, input logic ov, input logic un);
    checkOutput({tag, ".count"}, 32'(cnt), 32'(mq.size()));
    checkOutput({tag, ".empty"}, 32'(e), 32'(mq.size() == 0));
    checkOutput({tag, ".full"}, 32'(f), 32'(mq.size() == DEPTH));
    checkOutput({tag, ".aempty"}, 32'(ae), 32'(mq.size() <= AE));
    checkOutput({tag, ".afull"}, 32'(af), 32'(mq.size() >= AF));
    checkOutput({tag, ".overflow"}, 32'(ov), 32'(mOv));
    checkOutput({tag, ".underflow"}, 32'(un), 32'(mUn));
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkFlags("std", busStd.data_count, busStd.empty, busStd.full, busStd.almost_empty,
                 busStd.almost_full, busStd.overflow, busStd.underflow);
      checkFlags("fwft", busFw.data_count, busFw.empty, busFw.full, busFw.almost_empty,
                 busFw.almost_full, busFw.overflow, busFw.underflow);
      checkOutput("std.data_read", 32'(busStd.data_read), 32'(mLast));
      if (mq.size() != 0) checkOutput("fwft.data_read", 32'(busFw.data_read), 32'(mq[0]));
    end
  end

  // One call = inputs held across exactly one rising edge, then back to idle.
  task automatic applyStimulus(input logic w, input logic [DW-1:0] wd, input logic r, input logic c);
    write     = w;
    dataWrite = wd;
    read      = r;
    clr       = c;
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    clr   = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("rst.count", 32'(busStd.data_count), 32'd0);
    checkOutput("rst.empty", 32'(busStd.empty), 32'd1);
    checkOutput("rst.aempty", 32'(busStd.almost_empty), 32'd1);
    checkOutput("rst.full", 32'(busStd.full), 32'd0);
    checkOutput("rst.afull", 32'(busStd.almost_full), 32'd0);
    checkOutput("rst.data_read", 32'(busStd.data_read), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
      checkOutput("fill.count", 32'(busStd.data_count), 32'(i + 1));
      if (i == 1) checkOutput("fill.aempty2", 32'(busStd.almost_empty), 32'd1);
      if (i == 2) checkOutput("fill.aempty3", 32'(busStd.almost_empty), 32'd0);
      if (i == 4) checkOutput("fill.afull5", 32'(busStd.almost_full), 32'd0);
      if (i == 5) checkOutput("fill.afull6", 32'(busStd.almost_full), 32'd1);
    end
    checkOutput("fill.full", 32'(busStd.full), 32'd1);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkOutput("ovf.flag", 32'(busStd.overflow), 32'd1);
    checkOutput("ovf.count", 32'(busStd.data_count), 32'd8);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("drain.data", 32'(busStd.data_read), 32'(i));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("udf.flag", 32'(busStd.underflow), 32'd1);
    checkOutput("udf.empty", 32'(busStd.empty), 32'd1);

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr.ovf", 32'(busStd.overflow), 32'd0);
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    checkOutput("wr_rd_empty.count", 32'(busStd.data_count), 32'd1);
    checkOutput("wr_rd_empty.udf", 32'(busStd.underflow), 32'd1);
    checkOutput("wr_rd_empty.fwft", 32'(busFw.data_read), 32'h11);
    checkOutput("wr_rd_empty.std", 32'(busStd.data_read), 32'h07);
    for (int i = 1; i < 8; i++) applyStimulus(1'b1, DW'(8'h11 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("wr_rd_full.count", 32'(busStd.data_count), 32'd7);
    checkOutput("wr_rd_full.ovf", 32'(busStd.overflow), 32'd1);
    checkOutput("wr_rd_full.std", 32'(busStd.data_read), 32'h11);
    checkOutput("wr_rd_full.fwft", 32'(busFw.data_read), 32'h12);

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
    checkOutput("stream.count", 32'(busStd.data_count), 32'd4);
    checkOutput("stream.std", 32'(busStd.data_read), 32'h4F);
    checkOutput("stream.fwft", 32'(busFw.data_read), 32'h50);

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("fwft.first", 32'(busFw.data_read), 32'hA5);
    checkOutput("fwft.empty", 32'(busFw.empty), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("fwft.pop_empty", 32'(busFw.empty), 32'd1);
    checkOutput("fwft.pop_count", 32'(busFw.data_count), 32'd0);

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("preclr.count", 32'(busStd.data_count), 32'd5);
    checkOutput("preclr.std", 32'(busStd.data_read), 32'h62);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
    checkOutput("clr.count", 32'(busStd.data_count), 32'd0);
    checkOutput("clr.empty", 32'(busStd.empty), 32'd1);
    checkOutput("clr.overflow", 32'(busStd.overflow), 32'd0);
    checkOutput("clr.underflow", 32'(busStd.underflow), 32'd0);
    checkOutput("clr.data_read", 32'(busStd.data_read), 32'h62);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(8'h70 + i), i[0], 1'b0);
    write = 1'b1;
    dataWrite = 8'h77;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.count", 32'(busStd.data_count), 32'd0);
    checkOutput("arst.empty", 32'(busStd.empty), 32'd1);
    checkOutput("arst.aempty", 32'(busStd.almost_empty), 32'd1);
    checkOutput("arst.full", 32'(busStd.full), 32'd0);
    checkOutput("arst.afull", 32'(busStd.almost_full), 32'd0);
    checkOutput("arst.overflow", 32'(busStd.overflow), 32'd0);
    checkOutput("arst.underflow", 32'(busStd.underflow), 32'd0);
    checkOutput("arst.data_read", 32'(busStd.data_read), 32'd0);
    write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("post_rst.fwft", 32'(busFw.data_read), 32'h5A);
    checkOutput("post_rst.count", 32'(busFw.data_count), 32'd1);
    @(negedge clk);
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO for same-domain buffering in the camera datapath, e.g. pixel line staging and capture-to-VGA buffers where both sides run on one clock. It is the single-clock generalisation of our asynchronous FIFO. It adds selectable standard or first-word-fall-through read mode, a full-range occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8, word width in bits.
- FIFO_DEPTH_WIDTH, 11, log2 of depth; DEPTH = 2**FIFO_DEPTH_WIDTH; legal 2..12.
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.
- AF_THRESH, DEPTH-4, almost_full level; legal 1..DEPTH.
- AE_THRESH, 4, almost_empty level; legal 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush, active high.
- write  in  1  write request.
- data_write  in  DATA_WIDTH  write data.
- read  in  1  read/pop request.
- data_read  out  DATA_WIDTH  read data.
- full, empty  out  1  occupancy == DEPTH / occupancy == 0.
- almost_full, almost_empty  out  1  occupancy >= AF_THRESH / occupancy <= AE_THRESH.
- data_count  out  FIFO_DEPTH_WIDTH+1  occupancy, 0..DEPTH inclusive.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Storage is a DEPTH x DATA_WIDTH array. It is never reset.
- Pointers are FIFO_DEPTH_WIDTH-bit binary and wrap naturally from DEPTH-1 to 0.
- Write accept: we = write && !full && !clr. It stores data_write at the write pointer and increments the write pointer.
- Read accept: re = read && !empty && !clr. It increments the read pointer.
- Count: count_next = count + we - re. All flags are registered from count_next, so flags and data_count always agree in the same cycle.
- Simultaneous we and re leave the count and all occupancy flags unchanged.
- At full, a write is rejected even when a read is accepted in the same cycle.
- At empty, a read is rejected even when a write is accepted in the same cycle.
- Standard mode (FWFT=0): on re, data_read is registered with mem[rd_ptr]. Otherwise data_read holds its last value.
- FWFT mode (FWFT=1): data_read = mem[rd_ptr] combinationally. It is valid whenever empty=0 and undefined-but-stable when empty=1. A re pops the displayed word.
- overflow sets on write && full && !clr. underflow sets on read && empty && !clr. Both hold until clr or rst_n.
- clr: pointers, count and error flags go to 0, and the flags take their reset values.
  - clr has priority: write and read in the same cycle are ignored and not flagged.
  - data_read is not cleared by clr.

## Timing
- Reset values:
  - data_count=0, empty=1, almost_empty=1, full=0, almost_full=0.
  - overflow=0, underflow=0.
  - data_read=0 (standard mode).
- Reset takes effect immediately on rst_n low. Operation resumes on the first edge after deassertion.
- Write at edge N: data_count, empty, almost_* and full update after edge N.
  - FWFT: the word is visible on data_read after edge N (zero extra latency).
- Read latency: standard mode data_read is valid after the edge that accepts re (1 cycle). FWFT has 0 cycles.
- Throughput: one write and one read per cycle sustained, including at the pointer wrap.
- Reset or clr mid-burst: the FIFO is empty after that edge. An in-flight write at that edge is lost.

## Test plan
- Fill/drain, DEPTH_WIDTH=3, standard mode.
  - Stimulus: write 0x00..0x07, then one extra write; read 8 times.
  - Required response: full=1 and data_count=8 after the 8th write; overflow=1 after the 9th write with memory unchanged; reads return 0x00..0x07 in order, each 1 cycle after its accepted read.
  - Then: a 9th read sets underflow=1 and empty=1.
- Thresholds, AF_THRESH=6, AE_THRESH=2.
  - Stimulus: write single words.
  - Required response: almost_empty drops after the 3rd write; almost_full rises after the 6th write; both track data_count exactly during the drain.
- Simultaneous access.
  - At count=8 (full), write+read: read accepted, write rejected, count=7, overflow=1.
  - At count=0, write+read: write accepted, read rejected, count=1, underflow=1.
  - At count=4, write+read for 20 cycles: count stays 4 and data stays in order across the pointer wrap.
- FWFT mode.
  - Stimulus: write 0xA5 into the empty FIFO.
  - Required response: data_read=0xA5 and empty=0 after the same edge; a read with nothing further written gives empty=1 and count=0 after the next edge.
- clr versus rst_n.
  - Stimulus: with count=5 and overflow=1, assert clr together with write and read.
  - Required response: count=0, empty=1, overflow=0, no new flags set, data_read unchanged.
  - Then: drive rst_n low asynchronously mid-burst; all outputs take their reset values before the next clk edge.
